// File: rtl/aes_pkg.sv
// Shared AES key-schedule helpers.
//   SBOX / sbox()  : forward S-box, byte-wide lookup
//   xtime()        : multiply by x in GF(2^8) (used to step Rcon)
//   RCON_INIT      : first round constant
//   key_nr/key_nk  : derive round count and key words from a key width
package aes_pkg;

    localparam logic [7:0] RCON_INIT = 8'h01;

    // Byte 0 sits in the MSBs so SBOX[b] indexes naturally.
    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    // 0x80 wraps to 0x1b through the reduction polynomial.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic int key_nk(input int key_len);
        return key_len / 32;
    endfunction

    function automatic int key_nr(input int key_len);
        return key_len / 32 + 6;
    endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on a 32-bit word.
//   word   : input word
//   result : S-box applied to each byte of word
module aes_sub_word
    import aes_pkg::*;
(
    input  logic [31:0] word,
    output logic [31:0] result
);

    always_comb begin
        result = '0;
        for (int k = 0; k < 4; k++) begin
            result[8*k +: 8] = sbox(word[8*k +: 8]);
        end
    end

endmodule

// File: rtl/aes_key_expand.sv
// Iterative AES key schedule, one 32-bit word per clock, feeding the
// decrypt core. Once complete, any round key can be read by index.
//   i_clk, i_rst : clock / asynchronous active-high reset
//   i_vld, i_key : start strobe and cipher key (word 0 in MSBs)
//   i_rk_idx     : round-key index to read (0..NR)
//   o_rk         : round key for the previous cycle's index (0 if invalid)
//   o_busy       : expansion in progress
//   o_vld        : schedule complete
module aes_key_expand
    import aes_pkg::*;
#(
    parameter int KEY_LEN = 192,
    parameter int NR      = 12,
    parameter int NK      = 6
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_vld,
    input  logic [32*NK-1:0]  i_key,
    input  logic [3:0]        i_rk_idx,
    output logic [127:0]      o_rk,
    output logic              o_busy,
    output logic              o_vld
);

    localparam int NW = 4 * (NR + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_EXPAND = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    if (NR != key_nr(KEY_LEN) || NK != key_nk(KEY_LEN)) begin : g_bad_params
        $error("aes_key_expand: NR/NK do not match KEY_LEN");
    end

    logic [1:0]  state;
    logic [5:0]  i_cnt;
    logic [7:0]  rcon;
    logic [2:0]  phase;
    logic [31:0] w [NW];

    logic        start;
    logic [31:0] prev, rot, sub, temp;

    // Expansion is only (re)started outside EXPAND; strobes mid-run are dropped.
    assign start = i_vld && (state != S_EXPAND);

    // A single SubWord instance serves both the phase-0 and the 256-bit
    // phase-4 paths; rotation is applied only on phase 0.
    assign prev = w[i_cnt - 6'd1];
    assign rot  = (phase == 3'd0) ? {prev[23:0], prev[31:24]} : prev;

    aes_sub_word u_sub_word (
        .word   (rot),
        .result (sub)
    );

    always_comb begin
        temp = prev;
        if (phase == 3'd0)
            temp = sub ^ {rcon, 24'h0};
        else if (NK == 8 && phase == 3'd4)
            temp = sub;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state  <= S_IDLE;
            o_busy <= 1'b0;
            o_vld  <= 1'b0;
            o_rk   <= '0;
            i_cnt  <= '0;
            rcon   <= '0;
            phase  <= '0;
        end else begin
            if (start) begin
                state  <= S_EXPAND;
                o_busy <= 1'b1;
                o_vld  <= 1'b0;
                i_cnt  <= 6'(NK);
                rcon   <= RCON_INIT;
                phase  <= '0;
            end else if (state == S_EXPAND) begin
                i_cnt <= i_cnt + 6'd1;
                phase <= (phase == 3'(NK - 1)) ? 3'd0 : phase + 3'd1;
                if (phase == 3'd0)
                    rcon <= xtime(rcon);
                if (i_cnt == 6'(NW - 1)) begin
                    state  <= S_DONE;
                    o_busy <= 1'b0;
                    o_vld  <= 1'b1;
                end
            end

            if (o_vld && i_rk_idx <= 4'(NR))
                o_rk <= {w[{i_rk_idx, 2'b00}], w[{i_rk_idx, 2'b01}],
                         w[{i_rk_idx, 2'b10}], w[{i_rk_idx, 2'b11}]};
            else
                o_rk <= '0;
        end
    end

    // Word store is intentionally left out of reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            if (start) begin
                for (int k = 0; k < NK; k++)
                    w[k] <= i_key[32*(NK-1-k) +: 32];
            end else if (state == S_EXPAND) begin
                w[i_cnt] <= w[i_cnt - 6'(NK)] ^ temp;
            end
        end
    end

endmodule

// File: tb/tb_aes_key_expand.sv
module tb_aes_key_expand;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [2:0]    vld = '0;
    logic [255:0]  key [3];
    logic [3:0]    idx [3];
    logic [127:0]  rk  [3];
    logic [2:0]    busy, done;

    int n_cmp = 0;
    int n_bad = 0;

    int NKS [3] = '{4, 6, 8};
    int NRS [3] = '{10, 12, 14};

    always #5 clk = ~clk;

    aes_key_expand #(.KEY_LEN(128), .NR(10), .NK(4)) u_dut128 (
        .i_clk(clk), .i_rst(rst), .i_vld(vld[0]), .i_key(key[0][255:128]),
        .i_rk_idx(idx[0]), .o_rk(rk[0]), .o_busy(busy[0]), .o_vld(done[0]));

    aes_key_expand u_dut192 (
        .i_clk(clk), .i_rst(rst), .i_vld(vld[1]), .i_key(key[1][255:64]),
        .i_rk_idx(idx[1]), .o_rk(rk[1]), .o_busy(busy[1]), .o_vld(done[1]));

    aes_key_expand #(.KEY_LEN(256), .NR(14), .NK(8)) u_dut256 (
        .i_clk(clk), .i_rst(rst), .i_vld(vld[2]), .i_key(key[2]),
        .i_rk_idx(idx[2]), .o_rk(rk[2]), .o_busy(busy[2]), .o_vld(done[2]));

    // ---------------- reference model ----------------
    logic [7:0]  sb [256];
    logic [31:0] mw [60];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 0;
        logic [7:0] x = a;
        for (int k = 0; k < 8; k++) begin
            if (b[k]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int s);
        return 8'((b << s) | (b >> (8 - s)));
    endfunction

    // S-box from its definition: GF(2^8) inverse followed by the affine map.
    task automatic build_sbox();
        for (int x = 0; x < 256; x++) begin
            logic [7:0] inv = 0;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                    ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] msub(input logic [31:0] v);
        return {sb[v[31:24]], sb[v[23:16]], sb[v[15:8]], sb[v[7:0]]};
    endfunction

    task automatic model_expand(input int nk, input int nr, input logic [255:0] k);
        logic [7:0]  rc = 8'h01;
        logic [31:0] t;
        for (int i = 0; i < nk; i++) mw[i] = k[255 - 32*i -: 32];
        for (int i = nk; i < 4 * (nr + 1); i++) begin
            t = mw[i-1];
            if (i % nk == 0) begin
                t = msub({t[23:0], t[31:24]}) ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end else if (nk == 8 && i % nk == 4) begin
                t = msub(t);
            end
            mw[i] = mw[i-nk] ^ t;
        end
    endtask

    function automatic logic [127:0] mrk(input int r);
        return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
    endfunction

    // ---------------- checking / driving ----------------
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic start(input int s, input logic [255:0] k);
        @(negedge clk);
        key[s] = k;
        vld[s] = 1'b1;
        @(posedge clk);
        #1 vld[s] = 1'b0;
    endtask

    // Counts edges from the start edge until o_vld; called right after start().
    task automatic wait_done(input int s, input int already, output int n);
        n = already;
        while (!done[s] && n < 200) begin
            @(posedge clk);
            #1 n++;
        end
    endtask

    task automatic read_rk(input int s, input int r, output logic [127:0] v);
        @(negedge clk);
        idx[s] = 4'(r);
        @(posedge clk);
        #1 v = rk[s];
    endtask

    task automatic run_and_check(input int s, input logic [255:0] k, input string tag);
        int n;
        logic [127:0] v;
        start(s, k);
        chk({tag, "_busy"}, {127'b0, busy[s]}, 128'd1);
        chk({tag, "_vld_low"}, {127'b0, done[s]}, 128'd0);
        wait_done(s, 0, n);
        chk({tag, "_latency"}, 128'(n), 128'(4 * (NRS[s] + 1) - NKS[s]));
        chk({tag, "_busy_end"}, {127'b0, busy[s]}, 128'd0);
        model_expand(NKS[s], NRS[s], k);
        for (int r = 0; r <= NRS[s]; r++) begin
            read_rk(s, r, v);
            chk($sformatf("%s_rk%0d", tag, r), v, mrk(r));
        end
        read_rk(s, NRS[s] + 1, v);
        chk({tag, "_rk_oob"}, v, 128'd0);
    endtask

    function automatic logic [255:0] rand_key();
        return {$urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom};
    endfunction

    logic [255:0] k128, k192, k256, ka, kb;
    logic [127:0] v;
    int           n;

    initial begin
        for (int s = 0; s < 3; s++) begin
            key[s] = '0;
            idx[s] = '0;
        end
        build_sbox();
        k128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
        k192 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
        k256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

        repeat (3) @(posedge clk);
        #1;
        for (int s = 0; s < 3; s++) begin
            chk($sformatf("reset_rk%0d", s), rk[s], 128'd0);
            chk($sformatf("reset_busy%0d", s), {127'b0, busy[s]}, 128'd0);
            chk($sformatf("reset_vld%0d", s), {127'b0, done[s]}, 128'd0);
        end
        @(negedge clk) rst = 1'b0;

        // Read before any schedule exists.
        read_rk(1, 0, v);
        chk("pre_vld_rk", v, 128'd0);

        // Published vectors.
        run_and_check(0, k128, "aes128");
        read_rk(0, 10, v);
        chk("aes128_fips_rk10", v, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        read_rk(0, 0, v);
        chk("aes128_fips_rk0", v, k128[255:128]);

        run_and_check(1, k192, "aes192");
        read_rk(1, 12, v);
        chk("aes192_fips_rk12", v, 128'ha4970a331a78dc09c418c271e3a41d5d);
        read_rk(1, 0, v);
        chk("aes192_fips_rk0", v, 128'h000102030405060708090a0b0c0d0e0f);
        read_rk(1, 13, v);
        chk("aes192_idx13", v, 128'd0);

        run_and_check(2, k256, "aes256");
        read_rk(2, 14, v);
        chk("aes256_fips_w59", {96'b0, v[31:0]}, 128'h706c631e);

        // Random keys on every width (restart from DONE each time).
        for (int it = 0; it < 3; it++)
            for (int s = 0; s < 3; s++)
                run_and_check(s, rand_key(), $sformatf("rnd%0d_%0d", it, s));

        // Start strobe mid-expansion must be ignored.
        ka = rand_key();
        kb = rand_key();
        start(1, ka);
        repeat (19) begin
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        key[1] = kb;
        vld[1] = 1'b1;
        @(posedge clk);
        #1 vld[1] = 1'b0;
        chk("ign_busy", {127'b0, busy[1]}, 128'd1);
        wait_done(1, 20, n);
        chk("ign_latency", 128'(n), 128'd46);
        model_expand(6, 12, ka);
        for (int r = 0; r <= 12; r++) begin
            read_rk(1, r, v);
            chk($sformatf("ign_rk%0d", r), v, mrk(r));
        end

        // Reset in the middle of an expansion; sel 0 is DONE with a live read.
        @(negedge clk) idx[0] = 4'd3;
        start(1, rand_key());
        repeat (14) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1 chk("pre_rst_rk0_live", {127'b0, (rk[0] != 0)}, 128'd1);
        @(negedge clk) rst = 1'b1;
        #1;
        chk("rst_busy", {127'b0, busy[1]}, 128'd0);
        chk("rst_vld", {127'b0, done[1]}, 128'd0);
        chk("rst_rk", rk[1], 128'd0);
        chk("rst_rk_other", rk[0], 128'd0);
        chk("rst_vld_other", {127'b0, done[0]}, 128'd0);
        @(negedge clk) rst = 1'b0;
        run_and_check(1, rand_key(), "post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/aes_key_expand.md
Name: aes_key_expand

Overview:
- Iterative AES key-schedule engine; sits directly upstream of the AES decrypt core and supplies its round keys.
- Accepts a 128/192/256-bit cipher key and expands it at one 32-bit word per clock into an internal round-key store.
- Once the schedule is complete, serves any round key by index, so the consumer can read keys in reverse order (Nr down to 0) for decryption.

Parameters:
- KEY_LEN, 192, cipher key width in bits (128/192/256).
- NR, 12, number of rounds (10/12/14); must match KEY_LEN.
- NK, 6, key length in 32-bit words (4/6/8); must match KEY_LEN.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  reset, asynchronous, active-high.
- i_vld  input  1  start strobe; i_key sampled when high and not busy.
- i_key  input  32*NK  cipher key; word 0 in the MSBs.
- i_rk_idx  input  4  round-key index to read, 0..NR.
- o_rk  output  128  registered round key for the previous cycle's i_rk_idx.
- o_busy  output  1  expansion in progress.
- o_vld  output  1  schedule complete; o_rk is valid.

Behaviour:
- Reset (asynchronous, i_rst=1): FSM=IDLE; o_busy=0, o_vld=0, o_rk=0; word counter and Rcon register cleared. The word store is not cleared.
- FSM states: IDLE, EXPAND, DONE.
- IDLE/DONE with i_vld=1 at edge T:
  - write w[0..NK-1] from i_key;
  - set i=NK, Rcon=8'h01, phase counter=0;
  - go to EXPAND; o_busy=1 and o_vld=0 from T.
- EXPAND: one word written per edge, i = NK .. 4*(NR+1)-1, computed as follows:
  - temp = w[i-1];
  - if phase==0: temp = SubWord(RotWord(temp)) ^ {Rcon,24'h0}, then advance Rcon by xtime (0x80 -> 0x1b);
  - else if NK==8 and phase==4: temp = SubWord(temp);
  - w[i] = w[i-NK] ^ temp.
- Phase is a mod-NK counter; no divider is used.
- Last word written at edge T+4*(NR+1)-NK, i.e. 40, 46 or 52 cycles after the start edge. At that same edge: FSM goes to DONE, o_busy=0, o_vld=1.
- i_vld while in EXPAND is ignored: no restart, no key capture.
- i_vld while in DONE restarts expansion; o_vld drops at that edge.
- Round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}, with w[4r] in bits [127:96].
- o_rk is registered, one-cycle read latency:
  - o_rk <= rk[i_rk_idx] when o_vld is high and i_rk_idx<=NR;
  - otherwise o_rk <= 0.
- Reset mid-EXPAND: all outputs return to reset values immediately. A following i_vld performs a full, correct expansion.
- o_vld stays high indefinitely until reset or restart.

Decomposition:
- Shared package aes_pkg:
  - S-box table/function;
  - xtime function;
  - Rcon initial constant;
  - function mapping KEY_LEN to NR and NK (for parameter checks).
- Sub-module aes_sub_word: purely combinational, four S-box lookups on a 32-bit word; one instance is used.
- Word store: a 4*(NR+1) x 32 register array inside the top module.

Test Plan:
- AES-128 (NR=10, NK=4), key 2b7e151628aed2a6abf7158809cf4f3c:
  - o_vld rises exactly 40 cycles after the i_vld edge;
  - idx 10 -> d014f9a8c9ee2589e13f0cc8b6630ca6;
  - idx 0 -> the key itself.
- AES-192 (defaults), key 000102030405060708090a0b0c0d0e0f1011121314151617:
  - o_vld after 46 cycles;
  - idx 12 -> a4970a331a78dc09c418c271e3a41d5d;
  - idx 0 -> 000102030405060708090a0b0c0d0e0f.
- AES-256 (NR=14, NK=8), key 603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4:
  - o_vld after 52 cycles;
  - last word of idx 14 = 706c631e (checks the phase==4 SubWord path).
- i_vld pulsed with a different key at cycle 20 of an AES-192 expansion -> ignored; results identical to the original key.
- i_rst pulsed at cycle 15 of an expansion -> o_vld=0, o_busy=0, o_rk=0 immediately; restart then gives correct keys.
- Read idx 13 with NR=12 -> o_rk=0; read before o_vld -> o_rk=0.
